// File: rtl/exe_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ALU, HI/LO with single-cycle multiply
// and 32-step restoring divider, data-SRAM request generation and the ds/ms handshake.
module exe_stage #(
  parameter int DS_TO_ES_BUS_WD = 164,
  parameter int ES_TO_MS_BUS_WD = 87,
  parameter int ES_FWD_BUS_WD   = 39
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_wen,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  logic                       es_valid_r;
  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus_r;

  logic [11:0] alu_op_s;
  logic [15:0] ext_s;
  logic        res_from_mem_s;
  logic        gr_we_s;
  logic        mem_we_s;
  logic [4:0]  dest_s;
  logic [31:0] src1_s;
  logic [31:0] src2_s;
  logic [31:0] rt_value_s;
  logic [31:0] pc_s;

  assign alu_op_s       = ds_to_es_bus_r[163:152];
  assign ext_s          = ds_to_es_bus_r[151:136];
  assign res_from_mem_s = ds_to_es_bus_r[135];
  assign gr_we_s        = ds_to_es_bus_r[134];
  assign mem_we_s       = ds_to_es_bus_r[133];
  assign dest_s         = ds_to_es_bus_r[132:128];
  assign src1_s         = ds_to_es_bus_r[127:96];
  assign src2_s         = ds_to_es_bus_r[95:64];
  assign rt_value_s     = ds_to_es_bus_r[63:32];
  assign pc_s           = ds_to_es_bus_r[31:0];

  logic is_sb_s, is_sh_s, is_sw_s, is_mult_s, is_multu_s, is_div_s, is_divu_s;
  logic is_mfhi_s, is_mflo_s, is_mthi_s, is_mtlo_s, is_any_div_s;

  assign is_sb_s      = ext_s[4];
  assign is_sh_s      = ext_s[5];
  assign is_sw_s      = ext_s[6];
  assign is_mult_s    = ext_s[7];
  assign is_multu_s   = ext_s[8];
  assign is_div_s     = ext_s[9];
  assign is_divu_s    = ext_s[10];
  assign is_mfhi_s    = ext_s[11];
  assign is_mflo_s    = ext_s[12];
  assign is_mthi_s    = ext_s[13];
  assign is_mtlo_s    = ext_s[14];
  assign is_any_div_s = is_div_s | is_divu_s;

  div_state_t  div_state_r;
  logic [4:0]  div_cnt_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvs_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic es_ready_go_s;
  logic es_fire_s;

  assign es_ready_go_s  = is_any_div_s ? (div_state_r == DIV_DONE) : 1'b1;
  assign es_allowin     = !es_valid_r || (es_ready_go_s && ms_allowin);
  assign es_to_ms_valid = es_valid_r && es_ready_go_s;
  assign es_fire_s      = es_to_ms_valid && ms_allowin;

  // Pipeline valid bit and decode bus capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid_r     <= 1'b0;
      ds_to_es_bus_r <= {DS_TO_ES_BUS_WD{1'b0}};
    end else begin
      if (es_allowin) begin
        es_valid_r <= ds_to_es_valid;
      end
      if (ds_to_es_valid && es_allowin) begin
        ds_to_es_bus_r <= ds_to_es_bus;
      end
    end
  end

  logic [31:0] alu_result_s;
  logic [4:0]  shamt_s;
  assign shamt_s = src1_s[4:0];

  // One-hot ALU operation select
  always_comb begin
    alu_result_s = 32'd0;
    case (alu_op_s)
      12'b0000_0000_0001: alu_result_s = src1_s + src2_s;
      12'b0000_0000_0010: alu_result_s = src1_s - src2_s;
      12'b0000_0000_0100: alu_result_s = {31'd0, $signed(src1_s) < $signed(src2_s)};
      12'b0000_0000_1000: alu_result_s = {31'd0, src1_s < src2_s};
      12'b0000_0001_0000: alu_result_s = src1_s & src2_s;
      12'b0000_0010_0000: alu_result_s = ~(src1_s | src2_s);
      12'b0000_0100_0000: alu_result_s = src1_s | src2_s;
      12'b0000_1000_0000: alu_result_s = src1_s ^ src2_s;
      12'b0001_0000_0000: alu_result_s = src2_s << shamt_s;
      12'b0010_0000_0000: alu_result_s = src2_s >> shamt_s;
      12'b0100_0000_0000: alu_result_s = $signed(src2_s) >>> shamt_s;
      12'b1000_0000_0000: alu_result_s = {src2_s[15:0], 16'd0};
      default:            alu_result_s = 32'd0;
    endcase
  end

  // Divider works on magnitudes; signs are restored from the still-held operands at DONE.
  logic        dvd_neg_s, dvs_neg_s;
  logic [31:0] abs_a_s, abs_b_s;
  logic [32:0] trial_s;
  logic        trial_ge_s;
  logic [31:0] trial_sub_s;
  logic [31:0] div_q_s, div_r_s, div_hi_s, div_lo_s;

  assign dvd_neg_s   = is_div_s & src1_s[31];
  assign dvs_neg_s   = is_div_s & src2_s[31];
  assign abs_a_s     = dvd_neg_s ? (32'd0 - src1_s) : src1_s;
  assign abs_b_s     = dvs_neg_s ? (32'd0 - src2_s) : src2_s;
  assign trial_s     = {rem_r, quo_r[31]};
  assign trial_ge_s  = trial_s >= {1'b0, dvs_r};
  assign trial_sub_s = trial_s[31:0] - dvs_r;
  assign div_q_s     = (dvd_neg_s ^ dvs_neg_s) ? (32'd0 - quo_r) : quo_r;
  assign div_r_s     = dvd_neg_s ? (32'd0 - rem_r) : rem_r;
  assign div_hi_s    = (src2_s == 32'd0) ? src1_s : div_r_s;
  assign div_lo_s    = (src2_s == 32'd0) ? 32'hFFFF_FFFF : div_q_s;

  // Restoring divider FSM: one quotient bit per RUN cycle, result held in DONE until fire
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_state_r <= DIV_IDLE;
      div_cnt_r   <= 5'd0;
      rem_r       <= 32'd0;
      quo_r       <= 32'd0;
      dvs_r       <= 32'd0;
    end else begin
      case (div_state_r)
        DIV_IDLE: begin
          if (es_valid_r && is_any_div_s) begin
            div_state_r <= DIV_RUN;
            div_cnt_r   <= 5'd0;
            rem_r       <= 32'd0;
            quo_r       <= abs_a_s;
            dvs_r       <= abs_b_s;
          end
        end
        DIV_RUN: begin
          rem_r     <= trial_ge_s ? trial_sub_s : trial_s[31:0];
          quo_r     <= {quo_r[30:0], trial_ge_s};
          div_cnt_r <= div_cnt_r + 5'd1;
          if (div_cnt_r == 5'd31) begin
            div_state_r <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (es_fire_s) begin
            div_state_r <= DIV_IDLE;
          end
        end
        default: div_state_r <= DIV_IDLE;
      endcase
    end
  end

  // Sign-extending only for mult lets one 64-bit multiplier serve both signednesses.
  logic [63:0] mul_a_s, mul_b_s, mul_prod_s;
  assign mul_a_s    = {{32{is_mult_s & src1_s[31]}}, src1_s};
  assign mul_b_s    = {{32{is_mult_s & src2_s[31]}}, src2_s};
  assign mul_prod_s = mul_a_s * mul_b_s;

  // HI/LO update, committed only when the instruction leaves the stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (es_fire_s) begin
      if (is_mult_s || is_multu_s) begin
        hi_r <= mul_prod_s[63:32];
        lo_r <= mul_prod_s[31:0];
      end else if (is_any_div_s) begin
        hi_r <= div_hi_s;
        lo_r <= div_lo_s;
      end else if (is_mthi_s) begin
        hi_r <= src1_s;
      end else if (is_mtlo_s) begin
        lo_r <= src1_s;
      end
    end
  end

  logic [31:0] es_result_s;
  assign es_result_s = is_mfhi_s ? hi_r : (is_mflo_s ? lo_r : alu_result_s);

  assign es_to_ms_bus = {ext_s, res_from_mem_s, gr_we_s, dest_s, es_result_s, pc_s};
  assign es_fwd_bus   = {es_valid_r && gr_we_s, dest_s, res_from_mem_s, es_result_s};

  logic [3:0]  wen_s;
  logic [31:0] wdata_s;

  assign data_sram_en   = es_valid_r && (res_from_mem_s || mem_we_s) && ms_allowin && es_ready_go_s;
  assign data_sram_addr = src1_s + src2_s;

  // Store byte-lane enables and lane-replicated write data
  always_comb begin
    wen_s   = 4'b0000;
    wdata_s = rt_value_s;
    if (mem_we_s) begin
      if (is_sw_s) begin
        wen_s = 4'b1111;
      end else if (is_sh_s) begin
        wen_s   = 4'b0011 << {data_sram_addr[1], 1'b0};
        wdata_s = {2{rt_value_s[15:0]}};
      end else if (is_sb_s) begin
        wen_s   = 4'b0001 << data_sram_addr[1:0];
        wdata_s = {4{rt_value_s[7:0]}};
      end else begin
        wen_s = 4'b0000;
      end
    end else begin
      wen_s = 4'b0000;
    end
  end

  assign data_sram_wen   = wen_s;
  assign data_sram_wdata = wdata_s;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios followed by randomized
// instructions compared against an arithmetic reference model of ALU, HI/LO and stores.
module tb_exe_stage;

  logic         clk;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [163:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [86:0]  es_to_ms_bus;
  logic [38:0]  es_fwd_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  exe_stage dut (
    .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus), .es_fwd_bus(es_fwd_bus),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
  );

  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [15:0] E_NONE  = 16'h0000;
  localparam logic [15:0] E_LW    = 16'h0001;
  localparam logic [15:0] E_SB    = 16'h0010;
  localparam logic [15:0] E_SH    = 16'h0020;
  localparam logic [15:0] E_SW    = 16'h0040;
  localparam logic [15:0] E_MULT  = 16'h0080;
  localparam logic [15:0] E_MULTU = 16'h0100;
  localparam logic [15:0] E_DIV   = 16'h0200;
  localparam logic [15:0] E_DIVU  = 16'h0400;
  localparam logic [15:0] E_MFHI  = 16'h0800;
  localparam logic [15:0] E_MFLO  = 16'h1000;
  localparam logic [15:0] E_MTHI  = 16'h2000;
  localparam logic [15:0] E_MTLO  = 16'h4000;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: derive result and next HI/LO from the instruction's meaning.
  task automatic model(input logic [11:0] op, input logic [15:0] ext,
                       input logic [31:0] s1, input logic [31:0] s2,
                       output logic [31:0] res, output logic [31:0] nhi, output logic [31:0] nlo);
    int sel;
    longint sa, sb, q, r, p;
    logic [63:0] pu;
    sel = -1;
    for (int k = 0; k < 12; k++) if (op[k]) sel = k;
    sa = $signed(s1);
    sb = $signed(s2);
    case (sel)
      0: res = s1 + s2;
      1: res = s1 - s2;
      2: res = (sa < sb) ? 32'd1 : 32'd0;
      3: res = (s1 < s2) ? 32'd1 : 32'd0;
      4: res = s1 & s2;
      5: res = ~(s1 | s2);
      6: res = s1 | s2;
      7: res = s1 ^ s2;
      8: res = s2 << s1[4:0];
      9: res = s2 >> s1[4:0];
      10: begin p = sb >>> s1[4:0]; res = p[31:0]; end
      11: res = s2 * 32'd65536;
      default: res = 32'd0;
    endcase
    if (ext[11]) res = m_hi;
    if (ext[12]) res = m_lo;
    nhi = m_hi;
    nlo = m_lo;
    if (ext[7]) begin p = sa * sb; nhi = p[63:32]; nlo = p[31:0]; end
    if (ext[8]) begin pu = {32'd0, s1} * {32'd0, s2}; nhi = pu[63:32]; nlo = pu[31:0]; end
    if (ext[9] || ext[10]) begin
      if (s2 == 32'd0) begin
        nhi = s1; nlo = 32'hFFFF_FFFF;
      end else if (ext[9]) begin
        q = sa / sb; r = sa % sb; nlo = q[31:0]; nhi = r[31:0];
      end else begin
        nlo = s1 / s2; nhi = s1 % s2;
      end
    end
    if (ext[13]) nhi = s1;
    if (ext[14]) nlo = s1;
  endtask

  task automatic run_instr(input logic [11:0] op, input logic [15:0] ext, input logic rfm,
                           input logic gwe, input logic mwe, input logic [4:0] dest,
                           input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] rt,
                           input logic [31:0] pc, input int stall);
    logic [31:0] exp_res, nhi, nlo, addr, exp_wdata;
    logic [3:0]  exp_wen;
    int lat, exp_lat;
    model(op, ext, s1, s2, exp_res, nhi, nlo);
    addr = s1 + s2;
    exp_lat = (ext[9] || ext[10]) ? 33 : 0;
    exp_wen = 4'b0000;
    exp_wdata = rt;
    if (mwe && ext[6]) exp_wen = 4'b1111;
    else if (mwe && ext[5]) begin
      exp_wen = addr[1] ? 4'b1100 : 4'b0011;
      exp_wdata = {rt[15:0], rt[15:0]};
    end else if (mwe && ext[4]) begin
      case (addr[1:0])
        2'd0: exp_wen = 4'b0001;
        2'd1: exp_wen = 4'b0010;
        2'd2: exp_wen = 4'b0100;
        default: exp_wen = 4'b1000;
      endcase
      exp_wdata = {rt[7:0], rt[7:0], rt[7:0], rt[7:0]};
    end
    @(negedge clk);
    check_eq("allowin_empty", es_allowin, 1);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = {op, ext, rfm, gwe, mwe, dest, s1, s2, rt, pc};
    ms_allowin = (stall == 0);
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    ds_to_es_bus = '0;
    lat = 0;
    while (!es_to_ms_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", lat, exp_lat);
    for (int i = 0; i < stall; i++) begin
      check_eq("stall_allowin", es_allowin, 0);
      check_eq("stall_sram_en", data_sram_en, 0);
      check_eq("stall_valid", es_to_ms_valid, 1);
      @(negedge clk);
    end
    ms_allowin = 1'b1;
    #1;
    check_eq("result", es_to_ms_bus[63:32], exp_res);
    check_eq("ms_bus", es_to_ms_bus, {ext, rfm, gwe, dest, exp_res, pc});
    check_eq("fwd_bus", es_fwd_bus, {gwe, dest, rfm, exp_res});
    check_eq("sram_en", data_sram_en, rfm | mwe);
    check_eq("sram_addr", data_sram_addr, addr);
    check_eq("sram_wen", data_sram_wen, exp_wen);
    if (mwe) check_eq("sram_wdata", data_sram_wdata, exp_wdata);
    check_eq("allowin_go", es_allowin, 1);
    @(posedge clk);
    m_hi = nhi;
    m_lo = nlo;
    #1;
    check_eq("drained", es_to_ms_valid, 0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 20));
      1: return 32'd0 - 32'($urandom_range(1, 20));
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int kind, stall;
    logic [11:0] op;
    logic [15:0] ext;
    logic rfm, gwe, mwe;
    logic [31:0] s1, s2;
    m_hi = 32'd0;
    m_lo = 32'd0;
    reset = 1'b1;
    ms_allowin = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus = '0;
    #12;
    check_eq("rst_valid", es_to_ms_valid, 0);
    check_eq("rst_allowin", es_allowin, 1);
    check_eq("rst_sram_en", data_sram_en, 0);
    check_eq("rst_fwd", es_fwd_bus, 0);
    check_eq("rst_ms_bus", es_to_ms_bus, 0);
    check_eq("rst_wen", data_sram_wen, 0);
    @(negedge clk);
    reset = 1'b0;

    run_instr(OP_ADD, E_NONE, 0, 1, 0, 5'd3, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'hBFC0_0000, 0);
    run_instr(OP_ADD, E_SB, 0, 0, 1, 5'd0, 32'h1000, 32'd2, 32'h1234_56AB, 32'hBFC0_0004, 0);
    run_instr(OP_ADD, E_SH, 0, 0, 1, 5'd0, 32'h1000, 32'd2, 32'h1234_56AB, 32'hBFC0_0008, 0);
    run_instr(OP_ADD, E_DIV, 0, 0, 0, 5'd0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hBFC0_000C, 0);
    run_instr(OP_ADD, E_MFLO, 0, 1, 0, 5'd4, 32'd0, 32'd0, 32'd0, 32'hBFC0_0010, 0);
    run_instr(OP_ADD, E_MFHI, 0, 1, 0, 5'd5, 32'd0, 32'd0, 32'd0, 32'hBFC0_0014, 0);
    run_instr(OP_ADD, E_DIVU, 0, 0, 0, 5'd0, 32'd100, 32'd7, 32'd0, 32'hBFC0_0018, 5);
    run_instr(OP_ADD, E_MFLO, 0, 1, 0, 5'd6, 32'd0, 32'd0, 32'd0, 32'hBFC0_001C, 0);
    run_instr(OP_ADD, E_MFHI, 0, 1, 0, 5'd7, 32'd0, 32'd0, 32'd0, 32'hBFC0_0020, 0);
    run_instr(OP_ADD, E_MULT, 0, 0, 0, 5'd0, 32'h8000_0000, 32'd2, 32'd0, 32'hBFC0_0024, 0);
    run_instr(OP_ADD, E_MFHI, 0, 1, 0, 5'd8, 32'd0, 32'd0, 32'd0, 32'hBFC0_0028, 0);
    run_instr(OP_ADD, E_MFLO, 0, 1, 0, 5'd9, 32'd0, 32'd0, 32'd0, 32'hBFC0_002C, 0);

    // Reset in the middle of a divide
    @(negedge clk);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = {OP_ADD, E_DIV, 3'b000, 5'd0, 32'd1000, 32'd3, 32'd0, 32'hBFC0_0030};
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    ds_to_es_bus = '0;
    repeat (11) @(negedge clk);
    check_eq("div_busy_allowin", es_allowin, 0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_valid", es_to_ms_valid, 0);
    check_eq("midrst_allowin", es_allowin, 1);
    check_eq("midrst_fwd_we", es_fwd_bus[38], 0);
    check_eq("midrst_sram_en", data_sram_en, 0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    run_instr(OP_ADD, E_MFHI, 0, 1, 0, 5'd10, 32'd0, 32'd0, 32'd0, 32'hBFC0_0034, 0);
    run_instr(OP_ADD, E_DIVU, 0, 0, 0, 5'd0, 32'd9, 32'd0, 32'd0, 32'hBFC0_0038, 0);
    run_instr(OP_ADD, E_MFHI, 0, 1, 0, 5'd11, 32'd0, 32'd0, 32'd0, 32'hBFC0_003C, 0);
    run_instr(OP_ADD, E_MFLO, 0, 1, 0, 5'd12, 32'd0, 32'd0, 32'd0, 32'hBFC0_0040, 0);

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 24);
      op = OP_ADD;
      ext = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000;
      rfm = 1'b0; gwe = 1'b0; mwe = 1'b0;
      s1 = rnd_val();
      s2 = rnd_val();
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      if (kind < 12) begin
        op = 12'(1 << kind);
        gwe = 1'b1;
      end else begin
        case (kind)
          12: ext = ext | E_MULT;
          13: ext = ext | E_MULTU;
          14, 24: ext = ext | E_DIV;
          15: ext = ext | E_DIVU;
          16: ext = ext | E_MTHI;
          17: ext = ext | E_MTLO;
          18: begin ext = ext | E_MFHI; gwe = 1'b1; end
          19: begin ext = ext | E_MFLO; gwe = 1'b1; end
          20: begin ext = ext | E_SB; mwe = 1'b1; end
          21: begin ext = ext | E_SH; mwe = 1'b1; end
          22: begin ext = ext | E_SW; mwe = 1'b1; end
          default: begin ext = ext | 16'(E_LW << $urandom_range(0, 3)); rfm = 1'b1; gwe = 1'b1; end
        endcase
        if (kind >= 20 && kind <= 23) begin
          s1 = $urandom;
          s2 = 32'($urandom_range(0, 7));
        end
      end
      run_instr(op, ext, rfm, gwe, mwe, 5'($urandom_range(0, 31)), s1, s2, $urandom,
                $urandom, stall);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
